sc_if_stage: RTL and testbench
==============================

SC_IF_STAGE -- requirements
Module: sc_if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the PC loaded on reset.
REQ-002 clock  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset  in  1  SHALL be the reset: synchronous, active-high.
REQ-004 pcsource  in  2  SHALL be the next-PC select from the control unit: 00 pc+4, 01 branch, 10 jalr, 11 jal.
REQ-005 bra_offset  in  32  SHALL be the sign-extended B-type offset.
REQ-006 jal_offset  in  32  SHALL be the sign-extended J-type offset.
REQ-007 jalr_target  in  32  SHALL be the rs1+imm sum from the ALU.
REQ-008 retire  in  1  SHALL mean the core has consumed the current inst this cycle.
REQ-009 imem_req  out  1  SHALL be the instruction-memory read request.
REQ-010 imem_addr  out  32  SHALL be the read address, equal to pc.
REQ-011 imem_rvalid  in  1  SHALL mark imem_rdata valid.
REQ-012 imem_rdata  in  32  SHALL be the returned instruction word.
REQ-013 inst  out  32  SHALL be the held instruction presented to decode.
REQ-014 inst_valid  out  1  SHALL qualify inst.
REQ-015 pc  out  32  SHALL be the address of inst.
REQ-016 pc4  out  32  SHALL be pc+4, the link value.
REQ-017 misalign  out  1  SHALL be the sticky misaligned-target fault flag.

Function
REQ-018 FSM states SHALL be IDLE, REQ, VALID, FAULT.
REQ-019 IDLE SHALL go to REQ unconditionally on the next edge.
REQ-020 In REQ, imem_req SHALL be 1 and imem_addr SHALL stay stable until imem_rvalid; at most one request outstanding.
REQ-021 REQ with imem_rvalid=1 SHALL latch imem_rdata into inst and go to VALID; the same-cycle rvalid is accepted.
REQ-022 In VALID, inst_valid SHALL be 1 and imem_req 0; inst and pc SHALL hold until retire.
REQ-023 VALID with retire=1 SHALL compute next_pc from pcsource sampled that cycle: 00 pc+4; 01 pc+bra_offset; 10 {jalr_target[31:1],1'b0}; 11 pc+jal_offset.
REQ-024 All PC adds SHALL be 32-bit modulo 2^32 (0xFFFF_FFFC+4 = 0x0000_0000).
REQ-025 If next_pc[1:0]==00, pc SHALL load next_pc and the FSM SHALL go to REQ; imem_req rises the cycle after retire (1-cycle retire-to-request latency).
REQ-026 If next_pc[1:0]!=00, pc SHALL hold, misalign SHALL set, and the FSM SHALL go to FAULT.
REQ-027 FAULT SHALL be absorbing until reset: imem_req=0, inst_valid=0, misalign=1.
REQ-028 imem_rvalid outside REQ and retire outside VALID SHALL be ignored.
REQ-029 pc4 SHALL be combinational pc+4 at all times.

Reset
REQ-030 On reset=1 at an edge: state=IDLE, pc=RESET_PC, inst=32'h0000_0013 (NOP), inst_valid=0, imem_req=0, misalign=0.
REQ-031 Reset SHALL override every other input, including mid-REQ and in FAULT; a pending imem_rvalid in that cycle is discarded.

Structure
REQ-032 A shared package SHALL hold the FSM state enum, the NOP constant, and the pcsource encodings (PC_SEQ, PC_BRA, PC_JALR, PC_JAL) shared with the control unit.
REQ-033 Next-PC selection and the alignment check SHALL be one combinational sub-module, sc_npc.

Verification
REQ-034 Reset, then imem_rvalid with rdata 0x00500093 one cycle after imem_req -> imem_req at cycle 1 with addr 0x0; inst=0x00500093, inst_valid=1, pc=0x0, pc4=0x4.
REQ-035 pc=0x10, retire with pcsource=00 -> next imem_addr=0x14 one cycle later; imem_rvalid withheld 3 cycles -> imem_req and addr held, inst_valid=0.
REQ-036 pc=0x20, pcsource=01, bra_offset=0xFFFF_FFF8 -> pc=0x18; pcsource=11, jal_offset=0x100 from pc=0x18 -> pc=0x118.
REQ-037 pcsource=10, jalr_target=0x103 -> target 0x102, misalign=1, FAULT, pc unchanged, no further imem_req until reset.
REQ-038 pc=0xFFFF_FFFC, pcsource=00 retire -> pc=0x0000_0000, imem_addr=0x0.
REQ-039 Reset asserted during REQ with imem_rvalid=1 -> next edge imem_req=0, inst_valid=0, pc=RESET_PC, inst=0x00000013.

Source files
------------

// File: rtl/sc_if_pkg.sv
// Shared definitions for the single-cycle fetch stage and its control unit.
package sc_if_pkg;

  // Fetch FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_REQ   = 2'b01,
    ST_VALID = 2'b10,
    ST_FAULT = 2'b11
  } if_state_e;

  // Instruction presented to decode before the first fetch (addi x0, x0, 0).
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  // Next-PC select encodings driven by the control unit.
  localparam logic [1:0] PC_SEQ  = 2'b00;
  localparam logic [1:0] PC_BRA  = 2'b01;
  localparam logic [1:0] PC_JALR = 2'b10;
  localparam logic [1:0] PC_JAL  = 2'b11;

endpackage

// File: rtl/sc_npc.sv
// Next-PC selection and target alignment check (purely combinational).
module sc_npc
  import sc_if_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [1:0]  pcsource,
  input  logic [31:0] bra_offset,
  input  logic [31:0] jal_offset,
  input  logic [31:0] jalr_target,
  output logic [31:0] next_pc,
  output logic        misaligned
);

  // Select the candidate next PC; all adds wrap modulo 2^32.
  always_comb begin
    // NOTE: assigning a default before the case guarantees no latch is inferred.
    next_pc = pc + 32'd4;
    case (pcsource)
      PC_SEQ:  next_pc = pc + 32'd4;
      PC_BRA:  next_pc = pc + bra_offset;
      PC_JALR: next_pc = {jalr_target[31:1], 1'b0};
      PC_JAL:  next_pc = pc + jal_offset;
      default: next_pc = pc + 32'd4;
    endcase
  end

  // Instruction targets must be word aligned.
  assign misaligned = (next_pc[1:0] != 2'b00);

endmodule

// File: rtl/sc_if_stage.sv
// Instruction fetch stage: one outstanding imem request, holds the fetched
// instruction until the core retires it, then steers the PC.
module sc_if_stage
  import sc_if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  pcsource,
  input  logic [31:0] bra_offset,
  input  logic [31:0] jal_offset,
  input  logic [31:0] jalr_target,
  input  logic        retire,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic [31:0] pc,
  output logic [31:0] pc4,
  output logic        misalign
);

  if_state_e   state_q, state_d;
  logic [31:0] pc_q;
  logic [31:0] inst_q;
  logic [31:0] next_pc;
  logic        npc_misaligned;

  sc_npc u_npc (
    .pc          (pc_q),
    .pcsource    (pcsource),
    .bra_offset  (bra_offset),
    .jal_offset  (jal_offset),
    .jalr_target (jalr_target),
    .next_pc     (next_pc),
    .misaligned  (npc_misaligned)
  );

  // State register with synchronous reset.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: fetch, hold until retire, redirect or trap on misalignment.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  state_d = ST_REQ;
      ST_REQ:   if (imem_rvalid) state_d = ST_VALID;
      ST_VALID: if (retire) state_d = npc_misaligned ? ST_FAULT : ST_REQ;
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from the current state only.
  always_comb begin
    imem_req   = (state_q == ST_REQ);
    inst_valid = (state_q == ST_VALID);
    misalign   = (state_q == ST_FAULT);
  end

  // PC and instruction holding registers; rvalid and retire only count in their own states.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q   <= RESET_PC;
      inst_q <= NOP_INST;
    end else begin
      if (state_q == ST_REQ && imem_rvalid)
        inst_q <= imem_rdata;
      if (state_q == ST_VALID && retire && !npc_misaligned)
        pc_q <= next_pc;
    end
  end

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign pc4       = pc_q + 32'd4;
  assign inst      = inst_q;

endmodule

// File: tb/tb_sc_if_stage.sv
// Self-checking bench for sc_if_stage: directed boundary cases followed by a
// randomized fetch/retire walk, checked against a transaction-level PC model.
module tb_sc_if_stage;
  import sc_if_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  pcsource = 2'b00;
  logic [31:0] bra_offset = '0;
  logic [31:0] jal_offset = '0;
  logic [31:0] jalr_target = '0;
  logic        retire = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] inst;
  logic        inst_valid;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic        misalign;

  sc_if_stage #(.RESET_PC(RST_PC)) dut (
    .clock       (clock),
    .reset       (reset),
    .pcsource    (pcsource),
    .bra_offset  (bra_offset),
    .jal_offset  (jal_offset),
    .jalr_target (jalr_target),
    .retire      (retire),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .inst        (inst),
    .inst_valid  (inst_valid),
    .pc          (pc),
    .pc4         (pc4),
    .misalign    (misalign)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: architectural PC and the instruction last delivered.
  logic [31:0] m_pc;
  logic [31:0] m_inst;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reset for one edge (optionally with a competing rvalid), then release and
  // expect the request to rise one cycle later.
  task automatic do_reset(input bit with_rvalid);
    reset       = 1'b1;
    retire      = 1'b1;
    imem_rvalid = with_rvalid;
    imem_rdata  = $urandom;
    tick();
    reset       = 1'b0;
    retire      = 1'b0;
    imem_rvalid = 1'b0;
    m_pc        = RST_PC;
    m_inst      = NOP_INST;
    check("rst_imem_req",   32'(imem_req),   32'd0);
    check("rst_inst_valid", 32'(inst_valid), 32'd0);
    check("rst_pc",         pc,              RST_PC);
    check("rst_inst",       inst,            NOP_INST);
    check("rst_misalign",   32'(misalign),   32'd0);
    tick();
    check("req_rise",       32'(imem_req),   32'd1);
    check("req_addr",       imem_addr,       m_pc);
  endtask

  // Serve the outstanding request after 'waits' stalled cycles.
  task automatic fetch(input logic [31:0] word, input int waits);
    for (int i = 0; i < waits; i++) begin
      imem_rvalid = 1'b0;
      retire      = 1'($urandom);
      tick();
      check("stall_req",   32'(imem_req),   32'd1);
      check("stall_addr",  imem_addr,       m_pc);
      check("stall_valid", 32'(inst_valid), 32'd0);
    end
    retire      = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = word;
    tick();
    imem_rvalid = 1'b0;
    m_inst      = word;
    check("fetch_valid", 32'(inst_valid), 32'd1);
    check("fetch_req",   32'(imem_req),   32'd0);
    check("fetch_inst",  inst,            m_inst);
    check("fetch_pc",    pc,              m_pc);
    check("fetch_pc4",   pc4,             m_pc + 32'd4);
  endtask

  // Hold for 'holds' cycles with noise on ignored inputs, then retire.
  task automatic do_retire(input logic [1:0] src, input logic [31:0] bra,
                           input logic [31:0] jal, input logic [31:0] jalr,
                           input int holds);
    logic [31:0] target;
    for (int i = 0; i < holds; i++) begin
      retire      = 1'b0;
      imem_rvalid = 1'($urandom);
      imem_rdata  = $urandom;
      pcsource    = 2'($urandom);
      tick();
      check("hold_valid", 32'(inst_valid), 32'd1);
      check("hold_inst",  inst,            m_inst);
      check("hold_pc",    pc,              m_pc);
    end
    imem_rvalid = 1'b0;
    retire      = 1'b1;
    pcsource    = src;
    bra_offset  = bra;
    jal_offset  = jal;
    jalr_target = jalr;
    case (src)
      PC_SEQ:  target = m_pc + 32'd4;
      PC_BRA:  target = m_pc + bra;
      PC_JALR: target = jalr & 32'hFFFF_FFFE;
      default: target = m_pc + jal;
    endcase
    tick();
    retire = 1'b0;
    if (target % 4 == 0) begin
      m_pc = target;
      check("redir_req",      32'(imem_req),   32'd1);
      check("redir_addr",     imem_addr,       m_pc);
      check("redir_valid",    32'(inst_valid), 32'd0);
      check("redir_misalign", 32'(misalign),   32'd0);
    end else begin
      check("fault_misalign", 32'(misalign),   32'd1);
      check("fault_req",      32'(imem_req),   32'd0);
      check("fault_valid",    32'(inst_valid), 32'd0);
      check("fault_pc",       pc,              m_pc);
    end
  endtask

  // FAULT must absorb every input until reset.
  task automatic fault_hold(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      retire      = 1'($urandom);
      imem_rvalid = 1'($urandom);
      imem_rdata  = $urandom;
      pcsource    = 2'($urandom);
      tick();
      check("absorb_req",      32'(imem_req),   32'd0);
      check("absorb_valid",    32'(inst_valid), 32'd0);
      check("absorb_misalign", 32'(misalign),   32'd1);
      check("absorb_pc",       pc,              m_pc);
    end
    retire      = 1'b0;
    imem_rvalid = 1'b0;
  endtask

  initial begin
    logic [1:0]  r_src;
    logic [31:0] r_bra, r_jal, r_jalr;

    // Reset and first fetch.
    do_reset(1'b0);
    fetch(32'h0050_0093, 1);

    // Walk to pc=0x10, sequential retire, then a 3-cycle memory stall.
    do_retire(PC_JAL, 32'h0, 32'h10, 32'h0, 1);
    fetch($urandom, 0);
    do_retire(PC_SEQ, 32'h0, 32'h0, 32'h0, 2);
    fetch($urandom, 3);

    // Branch backwards from 0x20, then jal forward.
    do_retire(PC_JAL, 32'h0, 32'hC, 32'h0, 0);
    fetch($urandom, 0);
    do_retire(PC_BRA, 32'hFFFF_FFF8, 32'h0, 32'h0, 1);
    fetch($urandom, 1);
    do_retire(PC_JAL, 32'h0, 32'h100, 32'h0, 0);
    fetch($urandom, 0);

    // Wraparound at the top of the address space.
    do_retire(PC_JAL, 32'h0, 32'hFFFF_FEE4, 32'h0, 0);
    fetch($urandom, 0);
    do_retire(PC_SEQ, 32'h0, 32'h0, 32'h0, 1);
    fetch($urandom, 2);

    // jalr with bit 0 set is still aligned after clearing it.
    do_retire(PC_JALR, 32'h0, 32'h0, 32'h201, 0);
    fetch($urandom, 0);

    // Randomized walk with aligned targets.
    for (int n = 0; n < 25; n++) begin
      r_src  = 2'($urandom);
      r_bra  = $urandom & 32'hFFFF_FFFC;
      r_jal  = $urandom & 32'hFFFF_FFFC;
      r_jalr = $urandom & 32'hFFFF_FFFD;
      do_retire(r_src, r_bra, r_jal, r_jalr, $urandom_range(0, 2));
      fetch($urandom, $urandom_range(0, 3));
    end

    // Misaligned jalr traps and absorbs.
    do_retire(PC_JALR, 32'h0, 32'h0, 32'h103, 1);
    fault_hold(5);

    // Reset out of FAULT, then a misaligned branch.
    do_reset(1'b0);
    fetch($urandom, 0);
    do_retire(PC_BRA, 32'h6, 32'h0, 32'h0, 0);
    fault_hold(3);

    // Reset during REQ with a competing rvalid; the returned word is dropped.
    do_reset(1'b0);
    do_reset(1'b1);
    fetch(32'h0050_0093, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Guard against a stuck simulation.
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "simulation did not finish");
  end

endmodule
